// File: rtl/lbm_node_exchange.sv
// HPS<->FPGA node exchange for the lattice-Boltzmann accelerator: toggle-triggered
// capture into a small FIFO, valid/ready issue to the collision core, result latching.
`timescale 1ns/1ps
module lbm_node_exchange #(
    parameter int NUM_CH     = 9,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset_n,
    input  logic [NUM_CH*DATA_W-1:0]        hps_n_in,
    input  logic                            hps_req_toggle,
    input  logic                            hps_flush,
    output logic                            hps_ack_toggle,
    output logic [NUM_CH*DATA_W-1:0]        core_n_out,
    output logic                            core_valid,
    input  logic                            core_ready,
    input  logic [NUM_CH*DATA_W-1:0]        core_n_in,
    input  logic [DATA_W-1:0]               core_ux_in,
    input  logic [DATA_W-1:0]               core_uy_in,
    input  logic                            core_res_valid,
    output logic                            core_res_ready,
    output logic [NUM_CH*DATA_W-1:0]        fpga_n_out,
    output logic [DATA_W-1:0]               fpga_ux_out,
    output logic [DATA_W-1:0]               fpga_uy_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [$clog2(FIFO_DEPTH)+1:0]   pending,
    output logic [CNT_W-1:0]                done_count,
    output logic                            overflow,
    output logic                            busy
);
    localparam int VEC_W = NUM_CH * DATA_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int PW    = AW + 2;

    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [LW-1:0]    LVL_ZERO  = LW'(0);
    localparam logic [LW-1:0]    LVL_ONE   = LW'(1);
    localparam logic [LW-1:0]    LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [PW-1:0]    PEND_ZERO = PW'(0);
    localparam logic [PW-1:0]    PEND_ONE  = PW'(1);
    localparam logic [PW-1:0]    PEND_MAX  = {PW{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             req_prev_r;
    logic             req_pend_r;
    logic [VEC_W-1:0] stage_r;
    logic [VEC_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [LW-1:0]    level_r;
    logic [VEC_W-1:0] head_r;
    logic             overflow_r;
    logic [PW-1:0]    pending_r;
    logic             ack_r;
    logic [VEC_W-1:0] res_n_r;
    logic [DATA_W-1:0] res_ux_r;
    logic [DATA_W-1:0] res_uy_r;
    logic [CNT_W-1:0] done_r;
    logic             res_ready_r;

    logic             req_edge_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             res_take_s;
    logic [AW-1:0]    rd_next_s;
    logic [LW-1:0]    level_after_pop_s;
    logic [LW-1:0]    level_next_s;
    logic [VEC_W-1:0] head_next_s;
    logic [PW-1:0]    pending_next_s;

    assign req_edge_s        = hps_req_toggle ^ req_prev_r;
    assign full_s            = (level_r == LVL_FULL);
    assign core_valid        = (level_r != LVL_ZERO) && !hps_flush;
    assign pop_s             = core_valid && core_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_s            = req_pend_r && !hps_flush && (!full_s || pop_s);
    assign drop_s            = req_pend_r && !hps_flush && full_s && !pop_s;
    assign res_take_s        = core_res_valid && res_ready_r;
    assign rd_next_s         = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    assign level_after_pop_s = level_r - (pop_s ? LVL_ONE : LVL_ZERO);
    assign level_next_s      = level_after_pop_s + (push_s ? LVL_ONE : LVL_ZERO);

    // Next FIFO head: bypass the staged vector when it lands in an otherwise empty FIFO.
    always_comb begin
        head_next_s = head_r;
        if (push_s && (level_after_pop_s == LVL_ZERO)) begin
            head_next_s = stage_r;
        end else if (level_after_pop_s != LVL_ZERO) begin
            head_next_s = mem_r[rd_next_s];
        end else begin
            head_next_s = head_r;
        end
    end

    // Outstanding-issue count: saturating up on issue, floored down on result.
    always_comb begin
        pending_next_s = pending_r;
        case ({pop_s, res_take_s})
            2'b10: begin
                if (pending_r != PEND_MAX) pending_next_s = pending_r + PEND_ONE;
                else                       pending_next_s = pending_r;
            end
            2'b01: begin
                if (pending_r != PEND_ZERO) pending_next_s = pending_r - PEND_ONE;
                else                        pending_next_s = pending_r;
            end
            default: pending_next_s = pending_r;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge clk_clk) begin
        if (push_s) mem_r[wr_ptr_r] <= stage_r;
    end

    // Control, FIFO pointers and result registers.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            req_prev_r  <= hps_req_toggle;
            req_pend_r  <= 1'b0;
            stage_r     <= {VEC_W{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            level_r     <= LVL_ZERO;
            head_r      <= {VEC_W{1'b0}};
            overflow_r  <= 1'b0;
            pending_r   <= PEND_ZERO;
            ack_r       <= 1'b0;
            res_n_r     <= {VEC_W{1'b0}};
            res_ux_r    <= {DATA_W{1'b0}};
            res_uy_r    <= {DATA_W{1'b0}};
            done_r      <= {CNT_W{1'b0}};
            res_ready_r <= 1'b0;
        end else begin
            req_prev_r  <= hps_req_toggle;
            req_pend_r  <= req_edge_s && !hps_flush;
            res_ready_r <= 1'b1;
            pending_r   <= pending_next_s;
            if (req_edge_s) stage_r <= hps_n_in;
            if (hps_flush) begin
                rd_ptr_r   <= wr_ptr_r;
                level_r    <= LVL_ZERO;
                overflow_r <= 1'b0;
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
                rd_ptr_r <= rd_next_s;
                level_r  <= level_next_s;
                head_r   <= head_next_s;
                if (drop_s) overflow_r <= 1'b1;
            end
            if (res_take_s) begin
                res_n_r  <= core_n_in;
                res_ux_r <= core_ux_in;
                res_uy_r <= core_uy_in;
                ack_r    <= ~ack_r;
                done_r   <= done_r + CNT_ONE;
            end
        end
    end

    assign hps_ack_toggle = ack_r;
    assign core_n_out     = head_r;
    assign core_res_ready = res_ready_r;
    assign fpga_n_out     = res_n_r;
    assign fpga_ux_out    = res_ux_r;
    assign fpga_uy_out    = res_uy_r;
    assign fifo_level     = level_r;
    assign pending        = pending_r;
    assign done_count     = done_r;
    assign overflow       = overflow_r;
    assign busy           = (level_r != LVL_ZERO) || (pending_r != PEND_ZERO);
endmodule

// File: tb/tb_lbm_node_exchange.sv
// Scoreboard bench for lbm_node_exchange: directed scenarios plus randomized traffic
// checked against queue-based expectations for issued vectors and latched results.
`timescale 1ns/1ps
module tb_lbm_node_exchange;
    localparam int NCH = 9;
    localparam int DW  = 32;
    localparam int DEP = 4;
    localparam int CW  = 16;
    localparam int VW  = NCH * DW;
    localparam int LW  = $clog2(DEP) + 1;
    localparam int PW  = $clog2(DEP) + 2;

    typedef struct packed {
        logic [VW-1:0] n;
        logic [DW-1:0] ux;
        logic [DW-1:0] uy;
        logic [CW-1:0] done;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [VW-1:0] hps_n_in;
    logic          req_t;
    logic          flush;
    logic          ack;
    logic [VW-1:0] core_n_out;
    logic          core_valid;
    logic          core_ready;
    logic [VW-1:0] core_n_in;
    logic [DW-1:0] core_ux_in;
    logic [DW-1:0] core_uy_in;
    logic          res_valid;
    logic          res_ready;
    logic [VW-1:0] fpga_n;
    logic [DW-1:0] fpga_ux;
    logic [DW-1:0] fpga_uy;
    logic [LW-1:0] level;
    logic [PW-1:0] pending;
    logic [CW-1:0] done;
    logic          overflow;
    logic          busy;

    lbm_node_exchange #(.NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(DEP), .CNT_W(CW)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .hps_n_in(hps_n_in), .hps_req_toggle(req_t),
        .hps_flush(flush), .hps_ack_toggle(ack), .core_n_out(core_n_out),
        .core_valid(core_valid), .core_ready(core_ready), .core_n_in(core_n_in),
        .core_ux_in(core_ux_in), .core_uy_in(core_uy_in), .core_res_valid(res_valid),
        .core_res_ready(res_ready), .fpga_n_out(fpga_n), .fpga_ux_out(fpga_ux),
        .fpga_uy_out(fpga_uy), .fifo_level(level), .pending(pending), .done_count(done),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            passes = 0;
    int            issued = 0;
    int            returned = 0;
    bit            mon_res_en = 1'b1;
    logic [CW-1:0] exp_done = '0;
    logic [VW-1:0] iss_q [$];
    res_t          res_q [$];

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle_in(input logic [VW-1:0] v, input bit expect_accept);
        hps_n_in = v;
        req_t    = ~req_t;
        if (expect_accept) iss_q.push_back(v);
    endtask

    // Drives one result for the coming edge; caller advances time and clears res_valid.
    task automatic send_res(input logic [VW-1:0] n, input logic [DW-1:0] x, input logic [DW-1:0] y);
        res_t r;
        core_n_in  = n;
        core_ux_in = x;
        core_uy_in = y;
        res_valid  = 1'b1;
        exp_done   = exp_done + 1'b1;
        r.n = n; r.ux = x; r.uy = y; r.done = exp_done;
        res_q.push_back(r);
        returned++;
    endtask

    // Monitor: compares issued vectors, stall stability and latched results on the falling edge.
    task automatic monitor();
        bit            prev_stall = 1'b0;
        logic [VW-1:0] prev_out = '0;
        logic          ack_prev = 1'b0;
        res_t          r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall && core_valid) chk("stall_hold", core_n_out, prev_out);
                if (core_valid && core_ready) begin
                    issued++;
                    if (iss_q.size() == 0) begin
                        checks++;
                        $display("FAIL issue_unexpected: actual %0h required none", core_n_out);
                    end else begin
                        chk("issue_data", core_n_out, iss_q.pop_front());
                    end
                end
                prev_stall = core_valid && !core_ready;
                prev_out   = core_n_out;
                if (ack !== ack_prev && mon_res_en) begin
                    if (res_q.size() == 0) begin
                        checks++;
                        $display("FAIL result_unexpected: actual ack %0b required no flip", ack);
                    end else begin
                        r = res_q.pop_front();
                        chk("res_n", fpga_n, r.n);
                        chk("res_ux", fpga_ux, r.ux);
                        chk("res_uy", fpga_uy, r.uy);
                        chk("res_done", done, r.done);
                    end
                end
                ack_prev = ack;
            end else begin
                prev_stall = 1'b0;
                ack_prev   = 1'b0;
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VW-1:0] v;
        logic [VW-1:0] vecs [6];
        logic [CW-1:0] to_max;
        int            guard;

        rst_n = 1'b0; req_t = 1'b1; flush = 1'b0; core_ready = 1'b0; res_valid = 1'b0;
        hps_n_in = '0; core_n_in = '0; core_ux_in = '0; core_uy_in = '0;
        fork monitor(); join_none

        // Reset with the request toggle high: everything zero, nothing captured afterwards.
        step(3);
        chk("rst_level", level, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ack", ack, 0);
        chk("rst_valid", core_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_fpga_n", fpga_n, 0);
        chk("rst_core_n", core_n_out, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step(3);
        chk("idle_level", level, 0);
        chk("idle_valid", core_valid, 0);
        chk("idle_res_ready", res_ready, 1);

        // Single node: two-cycle latency to core_valid, then one result back.
        for (int k = 0; k < NCH; k++) v[k*DW +: DW] = 32'h100 + k;
        core_ready = 1'b1;
        toggle_in(v, 1'b1);
        step(1);
        chk("lat_valid_c1", core_valid, 0);
        step(1);
        chk("lat_valid_c2", core_valid, 1);
        chk("lat_data", core_n_out, v);
        step(1);
        chk("single_pending", pending, 1);
        chk("single_level", level, 0);
        for (int k = 0; k < NCH; k++) v[k*DW +: DW] = 32'h200 + k;
        send_res(v, 32'd5, 32'hFFFF_FFFD);
        step(1);
        res_valid = 1'b0;
        chk("single_ack", ack, 1);
        chk("single_done", done, 1);
        chk("single_pending0", pending, 0);
        chk("single_busy", busy, 0);

        // Backpressure: six requests into a four-deep FIFO, last two dropped.
        core_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vecs[i] = rand_vec();
            toggle_in(vecs[i], i < DEP);
            step(1);
        end
        step(3);
        chk("ovf_level", level, DEP);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", core_n_out, vecs[0]);
        core_ready = 1'b1;
        step(6);
        core_ready = 1'b0;
        chk("ovf_drained", level, 0);
        chk("ovf_queue_empty", iss_q.size(), 0);
        chk("ovf_sticky", overflow, 1);
        while (issued > returned) begin
            send_res(rand_vec(), $urandom, $urandom);
            step(1);
        end
        res_valid = 1'b0;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("flush_clears_ovf", overflow, 0);

        // Full FIFO with a request landing on the same edge as a pop.
        for (int i = 0; i < DEP; i++) begin
            toggle_in(rand_vec(), 1'b1);
            step(1);
        end
        step(3);
        chk("pp_full", level, DEP);
        toggle_in(rand_vec(), 1'b1);
        step(1);
        core_ready = 1'b1;
        step(1);
        core_ready = 1'b0;
        step(1);
        chk("pp_level", level, DEP);
        chk("pp_ovf", overflow, 0);
        chk("pp_pending", pending, 1);

        // Flush with three queued and one outstanding; a same-cycle request is discarded.
        core_ready = 1'b1;
        step(1);
        core_ready = 1'b0;
        send_res(rand_vec(), $urandom, $urandom);
        step(1);
        res_valid = 1'b0;
        chk("pre_flush_level", level, 3);
        chk("pre_flush_pending", pending, 1);
        flush = 1'b1;
        toggle_in(rand_vec(), 1'b0);
        step(1);
        flush = 1'b0;
        iss_q.delete();
        chk("flush_level", level, 0);
        chk("flush_ovf", overflow, 0);
        chk("flush_pending", pending, 1);
        step(3);
        chk("flush_discard", level, 0);
        chk("flush_valid", core_valid, 0);
        send_res(rand_vec(), $urandom, $urandom);
        step(1);
        res_valid = 1'b0;
        chk("post_flush_pending", pending, 0);

        // Randomized traffic with random backpressure and result timing.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            res_valid  = 1'b0;
            core_ready = 1'($urandom_range(0, 1));
            if (iss_q.size() < DEP && $urandom_range(0, 2) == 0) toggle_in(rand_vec(), 1'b1);
            if (issued > returned && $urandom_range(0, 2) == 0)
                send_res(rand_vec(), $urandom, $urandom);
            step(1);
        end
        res_valid  = 1'b0;
        core_ready = 1'b1;
        guard = 0;
        while ((iss_q.size() != 0 || issued != returned) && guard < 500) begin
            res_valid = 1'b0;
            if (issued > returned) send_res(rand_vec(), $urandom, $urandom);
            step(1);
            guard++;
        end
        res_valid = 1'b0;
        step(2);
        chk("rand_iss_left", iss_q.size(), 0);
        chk("rand_res_left", res_q.size(), 0);
        chk("rand_pending", pending, 0);
        chk("rand_busy", busy, 0);
        chk("rand_done", done, exp_done);

        // Unsolicited results until the completion counter wraps.
        mon_res_en = 1'b0;
        to_max = 16'hFFFF - exp_done;
        core_n_in = '0; core_ux_in = '0; core_uy_in = '0;
        res_valid = 1'b1;
        for (int i = 0; i < int'(to_max); i++) begin
            exp_done = exp_done + 1'b1;
            step(1);
        end
        res_valid = 1'b0;
        step(1);
        chk("wrap_max", done, exp_done);
        res_valid = 1'b1;
        exp_done = exp_done + 1'b1;
        step(1);
        res_valid = 1'b0;
        step(1);
        chk("wrap_zero", done, exp_done);
        chk("wrap_pending", pending, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/lbm_node_exchange.md
Name: lbm_node_exchange

Overview:
- Parametrised HPS↔FPGA exchange block for the lattice-Boltzmann accelerator.
- Captures one node's distribution vector (NUM_CH channels, D2Q9 by default) from the HPS-written PIO exports when the HPS flips a request toggle, and queues it in a small FIFO.
- Issues each queued vector to the collision core over a valid/ready handshake.
- Latches returned distributions plus ux/uy into HPS-readable registers and flips an ack toggle per result.
- Replaces direct per-direction PIO wiring with a buffered, flow-controlled path.

Parameters:
- NUM_CH, 9, distribution channels per node (must be ≥1).
- DATA_W, 32, bits per channel (fixed-point word width).
- FIFO_DEPTH, 4, queued node vectors (power of two, ≥2).
- CNT_W, 16, width of the completed-node counter.

Ports:
- clk_clk  in  1  single system clock.
- reset_reset_n  in  1  synchronous active-low reset.
- hps_n_in  in  NUM_CH*DATA_W  node vector from HPS PIOs; channel k occupies bits [k*DATA_W +: DATA_W].
- hps_req_toggle  in  1  HPS flips this level to request capture of hps_n_in.
- hps_flush  in  1  level; when 1, input FIFO is emptied and overflow is cleared.
- hps_ack_toggle  out  1  flips once per result latched.
- core_n_out  out  NUM_CH*DATA_W  vector to the collision core.
- core_valid  out  1  core_n_out valid.
- core_ready  in  1  core accepts.
- core_n_in  in  NUM_CH*DATA_W  post-collision vector.
- core_ux_in  in  DATA_W  node x-velocity.
- core_uy_in  in  DATA_W  node y-velocity.
- core_res_valid  in  1  result valid.
- core_res_ready  out  1  block accepts result.
- fpga_n_out  out  NUM_CH*DATA_W  last result vector (to HPS PIOs).
- fpga_ux_out  out  DATA_W  last ux.
- fpga_uy_out  out  DATA_W  last uy.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued vectors.
- pending  out  $clog2(FIFO_DEPTH)+2  issued but not yet returned; saturates at all-ones.
- done_count  out  CNT_W  results latched since reset, wraps at 2^CNT_W.
- overflow  out  1  sticky: request arrived while FIFO full.
- busy  out  1  fifo_level≠0 or pending≠0.

Behaviour:
- Reset (reset_reset_n=0 at clk_clk rising edge):
  - All outputs are 0, FIFO is empty.
  - The internal req_prev register loads the current hps_req_toggle, so no spurious capture occurs after reset.
- Request detect:
  - req_edge = hps_req_toggle XOR req_prev; req_prev is updated every cycle.
  - hps_req_toggle is quasi-static (HPS-driven); no synchroniser is required.
- Push:
  - On req_edge, if the FIFO is not full (or a pop occurs in the same cycle), write hps_n_in; fifo_level updates the next cycle.
  - If the FIFO is full and no same-cycle pop occurs, the vector is dropped and overflow is set to 1.
- Issue:
  - core_valid = (fifo_level≠0) and not hps_flush.
  - core_n_out = FIFO head, registered so that it is stable while valid.
  - Pop on core_valid & core_ready. Each pop increments pending.
  - core_n_out must not change while core_valid=1 and core_ready=0.
- Result path:
  - core_res_ready = 1 except during reset.
  - On core_res_valid: latch fpga_n_out/ux/uy, flip hps_ack_toggle, increment done_count (wrapping), and decrement pending. pending never decrements below 0.
  - An unsolicited result when pending=0 is still latched.
  - Outputs hold until the next result.
- Simultaneous events:
  - Issue and result in the same cycle: pending is unchanged.
  - Push and pop in the same cycle with the FIFO full: the push succeeds and fifo_level is unchanged.
- Flush:
  - While hps_flush=1: the FIFO empties at the next edge, overflow is cleared, and core_valid=0.
  - Any req_edge in the same cycle is discarded and does not set overflow.
  - pending and already-issued results are unaffected.
- Reset mid-operation: in-flight handshakes are abandoned; the core must also be reset.
- Latency:
  - req_edge to core_valid = 2 cycles (edge register, then FIFO head register) when the FIFO is empty.
  - core_res_valid to fpga_n_out/ack = 1 cycle.

Test Plan:
- Reset/idle: hold reset_reset_n=0 for 3 cycles with hps_req_toggle=1, then release → all outputs 0, no capture, fifo_level=0.
- Single node:
  - Stimulus: hps_n_in channel k = 0x100+k; flip toggle; core_ready=1.
  - Response: core_valid is asserted 2 cycles later with matching data, and pending=1.
  - Then return core_n_in = 0x200+k, ux=5, uy=-3 → fpga outputs match, hps_ack_toggle flips, done_count=1, pending=0, busy=0.
- Backpressure/overflow:
  - Stimulus: core_ready=0; six toggles of vectors A..F, with FIFO_DEPTH=4.
  - Response: fifo_level=4, overflow=1, core_n_out stays at A.
  - Then raise core_ready → A–D issued in order, E and F never appear.
- Full push+pop:
  - Stimulus: FIFO full; toggle in the same cycle as core_ready=1 pops.
  - Response: fifo_level stays 4, overflow stays 0.
- Flush: with 3 queued and pending=1, assert hps_flush for 1 cycle along with a toggle → fifo_level=0, overflow=0, pending=1, and the later result is still latched.
- Parameter sweep: NUM_CH=19, DATA_W=16, FIFO_DEPTH=8 → rerun the single-node and overflow scenarios; done_count wraps 0xFFFF→0 after 65536 results with CNT_W=16.
